// File: rtl/wb_mem_loader.sv
// Wishbone program loader and SRAM port arbiter for the instr/data memories.
// Define LOADER_READBACK_EN to allow DATA-window reads from SRAM (RD/RDW states).
module wb_mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [12:0] uP_instr_mem_addr,
    input  logic [7:0]  uP_data_mem_addr,
    input  logic [15:0] uP_write_data,
    input  logic        uP_dataw_en,
    input  logic        hlt,
    output logic        start,
    output logic [12:0] instr_mem_addr,
    output logic [15:0] instr_write_data,
    output logic        instrw_en,
    input  logic [15:0] instr,
    output logic [7:0]  data_mem_addr,
    output logic [15:0] data_write_data,
    output logic        dataw_en,
    input  logic [15:0] data_read_data
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PTR    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {IDLE, WR, ACK, RD, RDW} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, ACK} state_t;
`endif

    state_t      state_q;
    logic        run_q;
    logic        sel_q;
    logic        err_q;
    logic        hlt_q;
    logic        ack_q;
    logic [12:0] ptr_q;
    logic [15:0] readData_q;
    logic [15:0] writeData_q;
    logic        instrWe_q;
    logic        dataWe_q;

    logic        req;
    logic [1:0]  regSel;
    logic        haltRise;
    logic [12:0] ptrInc;
    logic [15:0] regRead;
    logic        unusedBits;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign regSel   = wbs_adr_i[3:2];
    assign haltRise = hlt & ~hlt_q;
    // The data memory only has 8 address bits, so its pointer wraps at 256 and drops the high bits.
    assign ptrInc   = sel_q ? {5'd0, ptr_q[7:0] + 8'd1} : ptr_q + 13'd1;
    assign unusedBits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16],
                          instr, data_read_data};

    always_comb begin
        regRead = 16'd0;
        case (regSel)
            REG_CTRL:   regRead = {14'd0, sel_q, run_q};
            REG_PTR:    regRead = {3'd0, ptr_q};
            REG_STATUS: regRead = {13'd0, err_q, run_q, hlt};
            default:    regRead = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
            hlt_q       <= 1'b0;
            ack_q       <= 1'b0;
            ptr_q       <= 13'd0;
            readData_q  <= 16'd0;
            writeData_q <= 16'd0;
            instrWe_q   <= 1'b1;
            dataWe_q    <= 1'b1;
        end else begin
            hlt_q     <= hlt;
            ack_q     <= 1'b0;
            instrWe_q <= 1'b1;
            dataWe_q  <= 1'b1;
            if (run_q && haltRise) begin
                run_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req && regSel == REG_DATA) begin
                        if (run_q) begin
                            err_q   <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                            if (!wbs_we_i) begin
                                readData_q <= 16'd0;
                            end
                        end else if (wbs_we_i) begin
                            writeData_q <= wbs_dat_i[15:0];
                            instrWe_q   <= sel_q;
                            dataWe_q    <= ~sel_q;
                            state_q     <= WR;
                        end else begin
`ifdef LOADER_READBACK_EN
                            state_q <= RD;
`else
                            readData_q <= 16'd0;
                            ack_q      <= 1'b1;
                            state_q    <= ACK;
`endif
                        end
                    end else if (req) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                        if (wbs_we_i) begin
                            // Placed after the halt clear so a same-cycle CTRL write takes priority.
                            case (regSel)
                                REG_CTRL: begin
                                    run_q <= wbs_dat_i[0];
                                    sel_q <= wbs_dat_i[1];
                                end
                                REG_PTR:    ptr_q <= wbs_dat_i[12:0];
                                REG_STATUS: err_q <= 1'b0;
                                default:    ;
                            endcase
                        end else begin
                            readData_q <= regRead;
                        end
                    end
                end
                WR: begin
                    ptr_q   <= ptrInc;
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
`ifdef LOADER_READBACK_EN
                RD: state_q <= RDW;
                RDW: begin
                    readData_q <= sel_q ? data_read_data : instr;
                    ptr_q      <= ptrInc;
                    ack_q      <= 1'b1;
                    state_q    <= ACK;
                end
`endif
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start     = run_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = {16'd0, readData_q};

    // Instruction memory stays read-only while the processor owns the ports.
    assign instr_mem_addr   = run_q ? uP_instr_mem_addr : ptr_q;
    assign instr_write_data = run_q ? uP_write_data     : writeData_q;
    assign instrw_en        = run_q ? 1'b1              : instrWe_q;
    assign data_mem_addr    = run_q ? uP_data_mem_addr  : ptr_q[7:0];
    assign data_write_data  = run_q ? uP_write_data     : writeData_q;
    assign dataw_en         = run_q ? uP_dataw_en       : dataWe_q;

endmodule
